// File: rtl/universal_shift_register.sv
// N-bit framed serialiser: load a word, then shift it out over exactly N enabled clocks
// in one of four shift/rotate, LSB/MSB-first modes, with busy/done framing and readback.

module usr_bit_cell (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  input  logic dir_left,
  input  logic ld_bit,
  input  logic from_hi,
  input  logic from_lo,
  output logic q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       q <= 1'b0;
    else if (load)  q <= ld_bit;
    else if (shift) q <= dir_left ? from_lo : from_hi;
  end
endmodule

module universal_shift_register #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [1:0]   mode,
  input  logic [N-1:0] parallel_in,
  input  logic         serial_in,
  input  logic         en,
  output logic         out,
  output logic [N-1:0] parallel_out,
  output logic         busy,
  output logic         done
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N);

  logic [N-1:0]  q, from_hi, from_lo;
  logic [1:0]    m;
  logic [CW-1:0] cnt;
  logic          shift, fill_r, fill_l;

  assign shift  = busy & en & ~load;
  // Rotate modes recirculate the outgoing end bit; shift modes take serial_in.
  assign fill_r = m[1] ? q[0]   : serial_in;
  assign fill_l = m[1] ? q[N-1] : serial_in;
  assign from_hi = {fill_r, q[N-1:1]};
  assign from_lo = {q[N-2:0], fill_l};

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_bit
      usr_bit_cell u_cell (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .dir_left (m[0]),
        .ld_bit   (parallel_in[i]),
        .from_hi  (from_hi[i]),
        .from_lo  (from_lo[i]),
        .q        (q[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m    <= 2'b00;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        m    <= mode;
        cnt  <= CNT_INIT;
        busy <= 1'b1;
      end else if (busy && en) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign out          = m[0] ? q[N-1] : q[0];
  assign parallel_out = q;
endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench: directed frame table, hand-written stall/reload/reset sequences,
// and a randomized run against an arithmetic reference model.

module tb_universal_shift_register;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [N-1:0] pin = '0;
  logic         sin = 1'b0;
  logic         en = 1'b0;
  logic         out;
  logic [N-1:0] pout;
  logic         busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  universal_shift_register #(.N(N)) dut (
    .clk(clk), .rst(rst), .load(load), .mode(mode), .parallel_in(pin),
    .serial_in(sin), .en(en), .out(out), .parallel_out(pout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: register value as an integer, shifted with plain arithmetic.
  logic [N-1:0] mq;
  logic [1:0]   mm;
  int           mrem;
  logic         mbusy, mdone;

  function automatic logic [N-1:0] model_next(logic [N-1:0] qv, logic [1:0] md, logic s);
    int v, top, fill;
    v   = int'(qv);
    top = 1 << (N - 1);
    case (md)
      2'd0: fill = int'(s);
      2'd1: fill = int'(s);
      2'd2: fill = v % 2;
      default: fill = v / top;
    endcase
    if (md[0]) v = ((v * 2) % (top * 2)) + fill;
    else       v = (v / 2) + fill * top;
    return v[N-1:0];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq <= '0; mm <= 2'b00; mrem <= 0; mbusy <= 1'b0; mdone <= 1'b0;
    end else begin
      mdone <= 1'b0;
      if (load) begin
        mq <= pin; mm <= mode; mrem <= N; mbusy <= 1'b1;
      end else if (mbusy && en) begin
        mq   <= model_next(mq, mm, sin);
        mrem <= mrem - 1;
        if (mrem == 1) begin
          mbusy <= 1'b0;
          mdone <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]   mode;
    logic [N-1:0] pin;
    logic         sin;
    logic [N-1:0] seq;    // bit k = expected out in cycle k after load
    logic [N-1:0] final_q;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [10:0] stall_exp;
    logic [N-1:0] f0;

    vt[0] = '{2'b00, 8'hAB, 1'b0, 8'hAB, 8'h00};
    vt[1] = '{2'b01, 8'hAB, 1'b0, 8'hD5, 8'h00};
    vt[2] = '{2'b10, 8'hAB, 1'b1, 8'hAB, 8'hAB};
    vt[3] = '{2'b00, 8'h00, 1'b1, 8'h00, 8'hFF};
    vt[4] = '{2'b11, 8'h81, 1'b0, 8'h81, 8'h81};
    vt[5] = '{2'b01, 8'h3C, 1'b1, 8'h3C, 8'hFF};

    // Reset state
    step(); step();
    check("rst_out", out, 0);
    check("rst_pout", pout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    en = 1'b1; sin = 1'b1;
    step();
    check("idle_en_pout", pout, 0);
    check("idle_en_busy", busy, 0);

    // Directed frame table
    for (int t = 0; t < 6; t++) begin
      load = 1'b1; mode = vt[t].mode; pin = vt[t].pin; sin = vt[t].sin; en = 1'b0;
      step();
      load = 1'b0; en = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (k > 0) step();
        check($sformatf("tbl%0d_out%0d", t, k), out, vt[t].seq[k]);
        check($sformatf("tbl%0d_busy%0d", t, k), busy, 1);
        check($sformatf("tbl%0d_done%0d", t, k), done, 0);
      end
      step();
      check($sformatf("tbl%0d_done", t), done, 1);
      check($sformatf("tbl%0d_busy_end", t), busy, 0);
      check($sformatf("tbl%0d_pout", t), pout, vt[t].final_q);
      step();
      check($sformatf("tbl%0d_done_once", t), done, 0);
    end

    // Stall: en low for three cycles after the third bit
    stall_exp = 11'b10101000011;
    load = 1'b1; mode = 2'b00; pin = 8'hAB; sin = 1'b0;
    step();
    load = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) begin
        en = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
        step();
      end
      check($sformatf("stall_out%0d", c), out, stall_exp[c]);
      check($sformatf("stall_busy%0d", c), busy, 1);
      check($sformatf("stall_done%0d", c), done, 0);
    end
    en = 1'b1;
    step();
    check("stall_done", done, 1);
    check("stall_busy_end", busy, 0);

    // Reload at the fourth shift, then change mode mid-frame
    f0 = 8'hF0;
    load = 1'b1; mode = 2'b00; pin = 8'hAB; sin = 1'b0;
    step();
    load = 1'b0;
    for (int c = 1; c < 4; c++) step();
    load = 1'b1; pin = f0;
    step();
    load = 1'b0; mode = 2'b01;
    check("reld_out0", out, f0[0]);
    check("reld_busy", busy, 1);
    for (int k = 1; k < N; k++) begin
      step();
      check($sformatf("reld_out%0d", k), out, f0[k]);
      check($sformatf("reld_done%0d", k), done, 0);
    end
    step();
    check("reld_done", done, 1);
    check("reld_pout", pout, 8'h00);

    // Load on the same edge as the final shift
    load = 1'b1; mode = 2'b00; pin = 8'h55;
    step();
    load = 1'b0;
    for (int c = 1; c < N; c++) step();
    load = 1'b1; mode = 2'b01; pin = 8'h80;
    step();
    load = 1'b0;
    check("fin_reld_done", done, 0);
    check("fin_reld_busy", busy, 1);
    check("fin_reld_out", out, 1);
    for (int c = 1; c < N; c++) begin
      step();
      check($sformatf("fin_reld_nodone%0d", c), done, 0);
    end
    step();
    check("fin_reld_done2", done, 1);

    // Asynchronous reset mid-frame
    load = 1'b1; mode = 2'b00; pin = 8'hFF; sin = 1'b1;
    step();
    load = 1'b0; en = 1'b1;
    step(); step();
    check("arst_pre_pout", pout, 8'hFF);
    #3 rst = 1'b0;
    #1;
    check("arst_out", out, 0);
    check("arst_pout", pout, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    #2 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("arst_idle_pout%0d", c), pout, 0);
      check($sformatf("arst_idle_busy%0d", c), busy, 0);
      check($sformatf("arst_idle_done%0d", c), done, 0);
    end

    // Randomized run against the reference model
    for (int c = 0; c < 500; c++) begin
      load = ($urandom_range(0, 11) == 0);
      mode = 2'($urandom);
      pin  = N'($urandom);
      sin  = 1'($urandom);
      en   = ($urandom_range(0, 3) != 0);
      step();
      check("rnd_out", out, (mm[0] ? mq[N-1] : mq[0]));
      check("rnd_pout", pout, mq);
      check("rnd_busy", busy, mbusy);
      check("rnd_done", done, mdone);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
